branch_conditional_unit: RTL
============================

// Module: branch_conditional_unit
// PURPOSE
// Execution stage directly downstream of the B-form decoder: consumes decoded Branch Conditional ops (opcode 25) on the branch functional unit.
// Evaluates BO/BI against the CR, owns the architected CTR and LR, computes the target, and emits a redirect to fetch.
// Two-stage pipeline, in-order, one op accepted per cycle.
// PARAMETERS
// addressWidth            64   instruction address / CTR / LR width
// instructionCounterWidth 64   major-ID width
// opcodeSize              12   decoded opcode width; only value 25 is executed
// bodyWidth               28   decoded body: BO[0:4] BI[5:9] BD[10:23] 00[24:25] AA[26] LK[27]
// crWidth                 32   CR width; BI indexes CR bit BI (ISA bit BI+32)
// PORTS
// clock_i              in   1    clock; all state on posedge
// reset_i              in   1    synchronous, active-high reset
// enable_i             in   1    decoded op valid this cycle
// stall_i              in   1    downstream stall; freezes both stages
// opcode_i             in   12   decoded opcode
// instructionAddress_i in   64   CIA of the op
// instMajId_i          in   64   major ID, passed through
// is64Bit_i            in   1    0 = 32-bit mode
// instructionBody_i    in   28   decoded body (layout above)
// crValue_i            in   32   current CR, sampled in stage 1
// ctrLoad_i            in   1    mtctr write strobe
// ctrLoadValue_i       in   64   mtctr value
// enable_o             out  1    result valid
// instMajId_o          out  64   major ID of the result
// taken_o              out  1    branch taken
// redirectAddress_o    out  64   NIA: target if taken, else CIA+4
// lrWrite_o            out  1    LK was 1 (LR updated)
// lrValue_o            out  64   architected LR
// ctrValue_o           out  64   architected CTR
// BEHAVIOUR
// - Reset: every output 0, CTR=0, LR=0, both stage-valid bits 0. Reset mid-operation discards in-flight ops; no CTR/LR change.
// - Accept: enable_i & !stall_i & opcode_i==25. Other opcodes ignored, no state change.
// - Stage 1 (accept cycle): latch body, CIA, ID, mode, CR bit BI.
//   If BO[2]==0: CTR <= CTR-1 (64-bit wrap: 0 -> all ones). CTR_M = 32-bit mode ? CTR[32:63] : CTR.
//   ctr_ok = BO[2] | ((CTR_M_after != 0) ^ BO[3]); cond_ok = BO[0] | (CR[BI] == BO[1]).
//   If LK: LR <= CIA+4, masked to low 32 bits in 32-bit mode.
//   Decrement and LR update happen whether or not taken.
// - Stage 2 (next cycle): disp = EXTS(BD||00) to 64. target = AA ? disp : CIA+disp (mod 2^64).
//   In 32-bit mode, target and CIA+4 are zero-extended from the low 32 bits.
//   taken_o = ctr_ok & cond_ok; redirectAddress_o = taken ? target : CIA+4. enable_o=1 for one cycle.
// - Latency: input to enable_o is exactly 2 cycles. Throughput 1/cycle.
//   Back-to-back bc sees the CTR already decremented by the older bc. No bubble.
// - stall_i=1: all stage registers, CTR, LR and outputs hold. enable_o keeps its value.
//   No acceptance and no CTR/LR update while stalled.
// - Without stall, enable_o drops to 0 the cycle after a result unless a new result is produced.
// - ctrLoad_i wins over a same-cycle decrement; it applies even under stall.
//   The same-cycle bc tests the pre-load CTR-1 value, but the final CTR = ctrLoadValue_i.
// - BO=1z1zz: always taken, CTR untouched. BO[0]=0 & BO[2]=0: both conditions required.
// - lrValue_o and ctrValue_o are the architected registers, updated in stage 1.
// STRUCTURE
// - Shared package ppc_branch_pkg: opcode 25 constant, BranchUnitID=6, BO bit indices, body-field offsets, bc_body_t packed struct.
// - Sub-module branch_cond_eval (combinational): inputs BO, crBit, CTR_M.
//   Outputs ctr_ok, cond_ok, decrement. Instantiated in stage 1.
// - Top module: CTR/LR registers, two pipeline registers, target adder, mode masking.
// TESTING
// - BO=10100, BD=0x0010, AA=0, LK=0, CIA=0x1000 -> 2 cycles later: taken=1, redirect=0x1040, CTR unchanged.
// - CTR=1, BO=10010 (bdz), CIA=0x2000 -> CTR=0, taken=1. Repeat -> CTR=0xFFFF_FFFF_FFFF_FFFF, taken=0, redirect=0x2004.
// - CR=0x8000_0000, BI=0, BO=01100 -> taken. BO=00100 -> not taken.
//   AA=1 with BD=0x3FFF -> redirect=0xFFFF_FFFF_FFFF_FFFC.
// - LK=1, CIA=0x1_0000_0000 in 32-bit mode -> lrWrite=1, LR=0x4, redirect masked to 32 bits.
// - stall_i high 3 cycles mid-stream -> outputs, CTR, LR frozen; released ops emerge in order, none lost or duplicated.
// - Reset during two in-flight ops -> enable_o=0, CTR=0, LR=0 next cycle. ctrLoad_i=0x5 with same-cycle bdnz -> CTR=0x5.

Source files
------------

// File: rtl/ppc_branch_pkg.sv
// Shared definitions for the branch functional unit.
//   - BC_OPCODE        : decoded opcode executed by branch_conditional_unit
//   - BRANCH_UNIT_ID   : functional-unit number of the branch unit
//   - BO_* indices     : BO bits in ISA (big-endian) numbering, BO[0] = MSB
//   - *_LSB / *_POS    : field offsets inside the 28-bit decoded body vector
//   - bc_body_t        : packed view of the decoded body, MSB first
package ppc_branch_pkg;

    localparam logic [11:0] BC_OPCODE      = 12'd25;
    localparam int          BRANCH_UNIT_ID = 6;

    // BO bit meanings (ISA numbering)
    localparam int BO_COND_IGNORE = 0;  // 1: ignore CR condition
    localparam int BO_COND_VALUE  = 1;  // CR bit value required
    localparam int BO_CTR_IGNORE  = 2;  // 1: leave CTR alone
    localparam int BO_CTR_ZERO    = 3;  // 1: branch on CTR==0, 0: on CTR!=0

    // Field offsets in the body vector (vector bit 27 is body bit 0)
    localparam int LK_POS = 0;
    localparam int AA_POS = 1;
    localparam int BD_LSB = 4;
    localparam int BI_LSB = 18;
    localparam int BO_LSB = 23;

    // Ranges are big-endian so field bit 0 is the ISA's bit 0 (the MSB).
    typedef struct packed {
        logic [0:4]  bo;
        logic [0:4]  bi;
        logic [0:13] bd;
        logic [1:0]  zero;
        logic        aa;
        logic        lk;
    } bc_body_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational BO evaluation for one bc op.
//   bo        : BO field, ISA numbering
//   cr_bit    : CR bit selected by BI
//   ctr_m     : CTR after any decrement, already mode-masked
//   ctr_ok    : CTR part of the branch condition holds
//   cond_ok   : CR part of the branch condition holds
//   decrement : this op decrements CTR
module branch_cond_eval
    import ppc_branch_pkg::*;
#(
    parameter int CTR_W = 64
) (
    input  logic [0:4]       bo,
    input  logic             cr_bit,
    input  logic [CTR_W-1:0] ctr_m,
    output logic             ctr_ok,
    output logic             cond_ok,
    output logic             decrement
);

    assign decrement = ~bo[BO_CTR_IGNORE];

    // BO[3] selects whether a zero or a non-zero CTR satisfies the test.
    assign ctr_ok  = bo[BO_CTR_IGNORE] | ((ctr_m != '0) ^ bo[BO_CTR_ZERO]);
    assign cond_ok = bo[BO_COND_IGNORE] | (cr_bit == bo[BO_COND_VALUE]);

endmodule

// File: rtl/branch_conditional_unit.sv
// Branch Conditional (bc) execution unit, two-stage in-order pipeline.
//   Stage 1 (accept edge): evaluates BO/BI, updates CTR and LR, latches op.
//   Stage 2 (next edge)  : computes target / NIA, registers the redirect.
// Ports:
//   clock_i, reset_i            : clock, synchronous active-high reset
//   enable_i, stall_i           : op valid, downstream stall (freezes pipe)
//   opcode_i                    : decoded opcode; only BC_OPCODE executes
//   instructionAddress_i        : CIA of the op
//   instMajId_i / instMajId_o   : major ID in / out with the result
//   is64Bit_i                   : 0 selects 32-bit mode
//   instructionBody_i           : decoded body (see bc_body_t)
//   crValue_i                   : current CR, sampled in stage 1
//   ctrLoad_i, ctrLoadValue_i   : mtctr write, applies even under stall
//   enable_o                    : result valid
//   taken_o, redirectAddress_o  : branch outcome and next instruction address
//   lrWrite_o                   : result had LK=1
//   lrValue_o, ctrValue_o       : architected LR and CTR
module branch_conditional_unit
    import ppc_branch_pkg::*;
#(
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 12,
    parameter int bodyWidth               = 28,
    parameter int crWidth                 = 32
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [instructionCounterWidth-1:0] instMajId_i,
    input  logic                               is64Bit_i,
    input  logic [bodyWidth-1:0]               instructionBody_i,
    input  logic [crWidth-1:0]                 crValue_i,
    input  logic                               ctrLoad_i,
    input  logic [addressWidth-1:0]            ctrLoadValue_i,
    output logic                               enable_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic                               taken_o,
    output logic [addressWidth-1:0]            redirectAddress_o,
    output logic                               lrWrite_o,
    output logic [addressWidth-1:0]            lrValue_o,
    output logic [addressWidth-1:0]            ctrValue_o
);

    localparam int STAGES = 2;
    localparam logic [4:0] CR_TOP = 5'(crWidth - 1);

    // ------------------------------------------------------------------
    // Stage 1 decode and condition evaluation
    // ------------------------------------------------------------------
    bc_body_t body;
    assign body = bc_body_t'(instructionBody_i);

    logic accept;
    assign accept = enable_i & ~stall_i & (opcode_i == opcodeSize'(BC_OPCODE));

    logic [addressWidth-1:0] ctr_q;
    logic [addressWidth-1:0] lr_q;
    logic [addressWidth-1:0] ctr_dec;
    logic [addressWidth-1:0] ctr_m;
    logic [addressWidth-1:0] cia_plus4_in;
    logic [addressWidth-1:0] lr_next;
    logic                    cr_bit;
    logic                    ctr_ok;
    logic                    cond_ok;
    logic                    decrement;

    assign ctr_dec = ctr_q - addressWidth'(1);

    // Only the low word of CTR counts in 32-bit mode.
    assign ctr_m = is64Bit_i ? ctr_dec : {{(addressWidth-32){1'b0}}, ctr_dec[31:0]};

    // BI counts from the CR MSB (ISA bit 32), so bit BI is vector bit 31-BI.
    assign cr_bit = crValue_i[CR_TOP - body.bi];

    assign cia_plus4_in = instructionAddress_i + addressWidth'(4);
    assign lr_next      = is64Bit_i ? cia_plus4_in
                                    : {{(addressWidth-32){1'b0}}, cia_plus4_in[31:0]};

    branch_cond_eval #(
        .CTR_W (addressWidth)
    ) u_eval (
        .bo        (body.bo),
        .cr_bit    (cr_bit),
        .ctr_m     (ctr_m),
        .ctr_ok    (ctr_ok),
        .cond_ok   (cond_ok),
        .decrement (decrement)
    );

    logic unused_body_zero;
    assign unused_body_zero = ^body.zero;

    // ------------------------------------------------------------------
    // Architected CTR and LR
    // ------------------------------------------------------------------
    // mtctr wins over a same-cycle decrement; the bc still tested CTR-1.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ctr_q <= '0;
        end else if (ctrLoad_i) begin
            ctr_q <= ctrLoadValue_i;
        end else if (accept && decrement) begin
            ctr_q <= ctr_dec;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lr_q <= '0;
        end else if (accept && body.lk) begin
            lr_q <= lr_next;
        end
    end

    assign ctrValue_o = ctr_q;
    assign lrValue_o  = lr_q;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [STAGES:1]                    vld_pipe;
    logic [addressWidth-1:0]            s1_cia;
    logic [instructionCounterWidth-1:0] s1_id;
    logic                               s1_is64;
    logic [0:13]                        s1_bd;
    logic                               s1_aa;
    logic                               s1_lk;
    logic                               s1_taken;

    // ------------------------------------------------------------------
    // Stage 2 target computation
    // ------------------------------------------------------------------
    logic [addressWidth-1:0] disp;
    logic [addressWidth-1:0] target_raw;
    logic [addressWidth-1:0] nia_raw;
    logic [addressWidth-1:0] target;
    logic [addressWidth-1:0] nia;
    logic [addressWidth-1:0] s2_redirect;

    assign disp       = {{(addressWidth-16){s1_bd[0]}}, s1_bd, 2'b00};
    assign target_raw = s1_aa ? disp : (s1_cia + disp);
    assign nia_raw    = s1_cia + addressWidth'(4);
    assign target     = s1_is64 ? target_raw : {{(addressWidth-32){1'b0}}, target_raw[31:0]};
    assign nia        = s1_is64 ? nia_raw    : {{(addressWidth-32){1'b0}}, nia_raw[31:0]};
    assign s2_redirect = s1_taken ? target : nia;

    // ------------------------------------------------------------------
    // Pipeline registers; stall freezes everything including enable_o.
    // ------------------------------------------------------------------
    logic [instructionCounterWidth-1:0] id_q;
    logic                               taken_q;
    logic [addressWidth-1:0]            redirect_q;
    logic                               lrwrite_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            vld_pipe   <= '0;
            s1_cia     <= '0;
            s1_id      <= '0;
            s1_is64    <= 1'b0;
            s1_bd      <= '0;
            s1_aa      <= 1'b0;
            s1_lk      <= 1'b0;
            s1_taken   <= 1'b0;
            id_q       <= '0;
            taken_q    <= 1'b0;
            redirect_q <= '0;
            lrwrite_q  <= 1'b0;
        end else if (!stall_i) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (accept) begin
                s1_cia   <= instructionAddress_i;
                s1_id    <= instMajId_i;
                s1_is64  <= is64Bit_i;
                s1_bd    <= body.bd;
                s1_aa    <= body.aa;
                s1_lk    <= body.lk;
                s1_taken <= ctr_ok & cond_ok;
            end
            if (vld_pipe[1]) begin
                id_q       <= s1_id;
                taken_q    <= s1_taken;
                redirect_q <= s2_redirect;
                lrwrite_q  <= s1_lk;
            end
        end
    end

    assign enable_o          = vld_pipe[STAGES];
    assign instMajId_o       = id_q;
    assign taken_o           = taken_q;
    assign redirectAddress_o = redirect_q;
    assign lrWrite_o         = lrwrite_q;

endmodule
